// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache.
// CPU side: 32-bit word accesses. Memory side: 16-byte blocks with a
// level-sensitive busywait handshake.
// Handshake: the CPU holds read/write/address/writedata stable while busywait
// is 1; the access completes on the first rising edge with busywait 0.
// Memory requests (mem_read/mem_write) stay high until the first edge where
// mem_busywait is 0 after it was seen high in the current state.
// Optional feature macro: DCACHE_PERF_CNT_EN adds hit_count and miss_count.
module dcache_controller #(
    parameter int NUM_LINES = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [1:0]   state_dbg
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [127:0]         data [NUM_LINES];
    logic [127:0]         fill_buf;
    logic                 started;

    logic                 access;
    logic                 hit;
    logic                 done;
    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           word;

    // Address decode, hit detection, CPU-facing combinational outputs
    always_comb begin
        access    = read ^ write;
        idx       = address[3+INDEX_W:4];
        req_tag   = address[31:4+INDEX_W];
        word      = address[3:2];
        hit       = valid[idx] && (tags[idx] == req_tag);
        readdata  = data[idx][{word, 5'd0} +: 32];
        busywait  = access && ((state != IDLE) || !hit);
        done      = started && !mem_busywait;
        state_dbg = state;
    end

    // Data/tag arrays and fill buffer (contents undefined after reset)
    always_ff @(posedge clock) begin
        if (state == IDLE && access && hit && write)
            data[idx][{word, 5'd0} +: 32] <= writedata;
        if (state == FETCH && done)
            fill_buf <= mem_readdata;
        if (state == ALLOCATE) begin
            data[idx] <= fill_buf;
            tags[idx] <= req_tag;
        end
    end

    // Controller FSM with registered memory-side outputs and line status bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            started       <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
`ifdef DCACHE_PERF_CNT_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (write)
                                dirty[idx] <= 1'b1;
`ifdef DCACHE_PERF_CNT_EN
                            hit_count <= hit_count + 32'd1;
`endif
                        end else begin
`ifdef DCACHE_PERF_CNT_EN
                            miss_count <= miss_count + 32'd1;
`endif
                            started <= 1'b0;
                            if (dirty[idx]) begin
                                state         <= WRITEBACK;
                                mem_write     <= 1'b1;
                                mem_address   <= {tags[idx], idx};
                                mem_writedata <= data[idx];
                            end else begin
                                state       <= FETCH;
                                mem_read    <= 1'b1;
                                mem_address <= {req_tag, idx};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (done) begin
                        state       <= FETCH;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= {req_tag, idx};
                        started     <= 1'b0;
                    end else if (mem_busywait) begin
                        started <= 1'b1;
                    end
                end
                FETCH: begin
                    if (done) begin
                        state    <= ALLOCATE;
                        mem_read <= 1'b0;
                        started  <= 1'b0;
                    end else if (mem_busywait) begin
                        started <= 1'b1;
                    end
                end
                default: begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed and randomized checks of dcache_controller
// against a line-level cache model plus an expected-memory image.
module tb_dcache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [1:0]   state_dbg;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // memory actually seen by the DUT, and what memory should hold per the model
    logic [127:0] mem_store [int];
    logic [127:0] exp_mem [int];

    // model cache lines
    bit           m_valid [8];
    bit           m_dirty [8];
    int           m_tag [8];
    logic [127:0] m_data [8];

    dcache_controller #(.NUM_LINES(8)) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .state_dbg(state_dbg)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] init_block(int b);
        logic [127:0] v;
        for (int w = 0; w < 4; w++)
            v[w*32 +: 32] = (b * 4 + w) ^ 32'h5A00_0000;
        return v;
    endfunction

    function automatic logic [127:0] get_store(int b);
        if (mem_store.exists(b)) return mem_store[b];
        return init_block(b);
    endfunction

    function automatic logic [127:0] get_exp(int b);
        if (exp_mem.exists(b)) return exp_mem[b];
        return init_block(b);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory responder: random busy period of 1..3 cycles per request
    initial begin
        int lat;
        lat = 0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mem_busywait = 1'b0;
                lat = 0;
            end else if (mem_busywait) begin
                lat--;
                if (lat <= 0) begin
                    if (mem_write) mem_store[int'(mem_address)] = mem_writedata;
                    else if (mem_read) mem_readdata = get_store(int'(mem_address));
                    mem_busywait = 1'b0;
                end
            end else if (mem_read || mem_write) begin
                mem_busywait = 1'b1;
                lat = $urandom_range(1, 3);
            end
        end
    end

    // one CPU access, checked against the model; model updated afterwards
    task automatic do_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd, input string nm);
        int idx = int'(addr[6:4]);
        int tg = int'(addr[31:7]);
        int w = int'(addr[3:2]);
        int blk = int'(addr[31:4]);
        bit exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        bit exp_wb = !exp_hit && m_dirty[idx];
        int victim_blk = m_tag[idx] * 8 + idx;
        logic [127:0] victim = m_data[idx];
        bit saw_wb = 0, saw_rd = 0, both = 0, order_bad = 0;
        logic [27:0] wb_addr = '0, rd_addr = '0;
        logic [127:0] wb_data = '0;
        int cycles = 0;
        @(negedge clock);
        read = !is_wr;
        write = is_wr;
        address = addr;
        writedata = wd;
        #1;
        check({nm, "_busy_initial"}, busywait, !exp_hit);
        while (busywait && cycles < 60) begin
            if (mem_read && mem_write) both = 1;
            if (mem_write) begin
                if (!saw_wb) begin wb_addr = mem_address; wb_data = mem_writedata; end
                saw_wb = 1;
                if (saw_rd) order_bad = 1;
            end
            if (mem_read) begin
                if (!saw_rd) rd_addr = mem_address;
                saw_rd = 1;
            end
            @(negedge clock);
            #1;
            cycles++;
        end
        check({nm, "_done_in_time"}, busywait, 1'b0);
        check({nm, "_saw_writeback"}, saw_wb, exp_wb);
        check({nm, "_saw_fetch"}, saw_rd, !exp_hit);
        check({nm, "_req_exclusive"}, both, 1'b0);
        check({nm, "_wb_before_fetch"}, order_bad, 1'b0);
        if (!exp_hit) begin
            exp_misses++;
            if (exp_wb) begin
                check({nm, "_wb_addr"}, wb_addr, victim_blk[27:0]);
                check({nm, "_wb_data"}, wb_data, victim);
                exp_mem[victim_blk] = victim;
            end
            check({nm, "_fetch_addr"}, rd_addr, blk[27:0]);
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx] = tg;
            m_data[idx] = get_exp(blk);
        end
        exp_hits++;
        if (!is_wr) check({nm, "_readdata"}, readdata, m_data[idx][w*32 +: 32]);
        else begin
            m_data[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1;
        end
        @(posedge clock);
        #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        logic [127:0] seed_blk;
        int found;
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;
        seed_blk = init_block(4);
        seed_blk[63:32] = 32'hDEADBEEF;
        mem_store[4] = seed_blk;
        exp_mem[4] = seed_blk;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_data[i] = '0;
        end
        repeat (3) @(negedge clock);
        #1;
        check("rst_busywait", busywait, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 28'h0);
        check("rst_mem_writedata", mem_writedata, 128'h0);
        check("rst_state", state_dbg, 2'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // clean read miss, then hit
        do_access(0, 32'h0000_0044, 32'h0, "rd44_miss");
        check("rd44_value", readdata, 32'hDEADBEEF);
        do_access(0, 32'h0000_0044, 32'h0, "rd44_hit");
        check("rd44_hit_value", readdata, 32'hDEADBEEF);

        // write hit then read back
        do_access(1, 32'h0000_0048, 32'h12345678, "wr48_hit");
        do_access(0, 32'h0000_0048, 32'h0, "rd48_hit");
        check("rd48_value", readdata, 32'h12345678);

        // dirty miss on the same index
        do_access(0, 32'h0000_00C4, 32'h0, "rdC4_dirty_miss");
        check("wb_word2_in_memory", mem_store[4][95:64], 32'h12345678);

        // write miss on a clean line
        do_access(1, 32'h0000_0100, 32'hCAFEF00D, "wr100_miss");
        do_access(0, 32'h0000_0100, 32'h0, "rd100_hit");
        check("rd100_value", readdata, 32'hCAFEF00D);

        // read and write together: no access
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 32'h0000_0100; writedata = 32'h0BAD_0BAD;
        #1;
        check("both_busywait", busywait, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        check("both_no_mem_read", mem_read, 1'b0);
        check("both_no_mem_write", mem_write, 1'b0);
        read = 1'b0; write = 1'b0;
        do_access(0, 32'h0000_0100, 32'h0, "rd100_after_both");
        check("rd100_unchanged", readdata, 32'hCAFEF00D);

        // randomized accesses over a few tags per index
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            do_access($urandom_range(0, 1) == 1, a, $urandom, "rand");
        end

`ifdef DCACHE_PERF_CNT_EN
        check("hit_count_total", hit_count, exp_hits);
        check("miss_count_total", miss_count, exp_misses);
`endif

        // reset during FETCH of a miss to a never-cached block
        @(negedge clock);
        read = 1'b1; write = 1'b0; address = 32'h0000_1234;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (mem_read && mem_busywait) found = 1;
            else @(negedge clock);
        end
        check("rst_mid_fetch_reached", found, 1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_mem_read", mem_read, 1'b0);
        check("rst_mid_mem_write", mem_write, 1'b0);
        check("rst_mid_state", state_dbg, 2'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_mid_hit_count", hit_count, 32'd0);
        check("rst_mid_miss_count", miss_count, 32'd0);
`endif
        @(posedge clock);
        #1;
        read = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end

        // previously cached lines now miss
        do_access(0, 32'h0000_0100, 32'h0, "rd100_after_rst");
        do_access(0, 32'h0000_0044, 32'h0, "rd44_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
